// File: rtl/hazard_detect.sv
// hazard_detect
// ID-stage read-after-write hazard detector for a 5-stage pipeline with no
// forwarding. It reports a stall code to the stall controller on the first
// cycle of a hazard. It drives the ID/EX bubble-insert control for every
// stall cycle. It also keeps a saturating count of bubble cycles, and it
// flags cycles where the pipeline state contradicts an outstanding stall.
//
// Ports:
//   clk           system clock, rising edge
//   rst           synchronous active-high reset
//   id_valid      ID stage holds a real instruction
//   id_rs/id_rt   ID source registers, with *_vld set when actually read
//   ex_wr_en/reg  EX-stage register-file write enable / destination
//   mem_wr_en/reg MEM-stage register-file write enable / destination
//   flush         redirect; squashes the ID instruction this cycle
//   stall_count   00 none, 01 one-cycle stall, 10 two-cycle stall
//   id_ex_bubble  load a NOP into ID/EX this cycle
//   busy          second cycle of a two-cycle stall in progress
//   err           inconsistency detected this cycle
//   stall_cycles  saturating count of cycles with id_ex_bubble=1
//
// state | meaning
// IDLE  | no stall in flight; a new hazard may be reported
// HOLD  | second bubble cycle of an EX hazard, now sitting in MEM

module hazard_detect #(
   parameter int REG_W = 3,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid,
   input  logic [REG_W-1:0] id_rs,
   input  logic             id_rs_vld,
   input  logic [REG_W-1:0] id_rt,
   input  logic             id_rt_vld,
   input  logic             ex_wr_en,
   input  logic [REG_W-1:0] ex_wr_reg,
   input  logic             mem_wr_en,
   input  logic [REG_W-1:0] mem_wr_reg,
   input  logic             flush,
   output logic [1:0]       stall_count,
   output logic             id_ex_bubble,
   output logic             busy,
   output logic             err,
   output logic [CNT_W-1:0] stall_cycles
);

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_t;

   state_t state;
   state_t state_nxt;
   logic   ex_hit;
   logic   mem_hit;
   logic   id_live;

   // The WB stage is not checked. The register file writes before it reads,
   // so a WB producer is never a hazard.
   assign ex_hit  = ex_wr_en  & ((id_rs_vld & (id_rs == ex_wr_reg))  |
                                 (id_rt_vld & (id_rt == ex_wr_reg)));
   assign mem_hit = mem_wr_en & ((id_rs_vld & (id_rs == mem_wr_reg)) |
                                 (id_rt_vld & (id_rt == mem_wr_reg)));
   assign id_live = id_valid & ~flush;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // The outputs are combinational, so the stall controller can pause in the
   // same cycle the hazard is seen. All outputs are forced low during reset.
   always_comb begin
      state_nxt    = IDLE;
      stall_count  = 2'b00;
      id_ex_bubble = 1'b0;
      busy         = 1'b0;
      err          = 1'b0;
      if (!rst) begin
         case (state)
            IDLE: begin
               if (id_live && ex_hit) begin
                  stall_count  = 2'b10;
                  id_ex_bubble = 1'b1;
                  state_nxt    = HOLD;
               end else if (id_live && mem_hit) begin
                  stall_count  = 2'b01;
                  id_ex_bubble = 1'b1;
               end
            end
            HOLD: begin
               // The producer has moved to MEM. The controller's second stall
               // cycle already covers it, so it is not reported again as 01.
               // On a flush the redirect logic owns ID/EX, so no bubble is
               // inserted.
               busy         = 1'b1;
               id_ex_bubble = ~flush;
               // In HOLD, EX must contain the bubble inserted on the
               // previous cycle. A write or a match in EX means it did not.
               err          = ex_wr_en | (~flush & ex_hit);
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cycles <= '0;
      end else if (id_ex_bubble && (stall_cycles != '1)) begin
         stall_cycles <= stall_cycles + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_hazard_detect.sv
// Bench for hazard_detect. Two instances share one stimulus: the default
// counter width and a 2-bit counter used to watch saturation. The reference
// model tracks the number of follow-on bubble cycles still owed, plus plain
// integer counters.

module tb_hazard_detect;

   logic       clk = 1'b0;
   logic       rst;
   logic       id_valid;
   logic [2:0] id_rs;
   logic       id_rs_vld;
   logic [2:0] id_rt;
   logic       id_rt_vld;
   logic       ex_wr_en;
   logic [2:0] ex_wr_reg;
   logic       mem_wr_en;
   logic [2:0] mem_wr_reg;
   logic       flush;

   logic [1:0]  sc_a, sc_b;
   logic        bub_a, bub_b, busy_a, busy_b, err_a, err_b;
   logic [15:0] cyc_a;
   logic [1:0]  cyc_b;

   int checks = 0;
   int errors = 0;
   int pend = 0;
   int cnt_big = 0;
   int cnt_small = 0;
   int cyc_no = 0;

   always #5 clk = ~clk;

   hazard_detect #(.REG_W(3), .CNT_W(16)) dut_a (
      .clk(clk), .rst(rst), .id_valid(id_valid),
      .id_rs(id_rs), .id_rs_vld(id_rs_vld), .id_rt(id_rt), .id_rt_vld(id_rt_vld),
      .ex_wr_en(ex_wr_en), .ex_wr_reg(ex_wr_reg),
      .mem_wr_en(mem_wr_en), .mem_wr_reg(mem_wr_reg), .flush(flush),
      .stall_count(sc_a), .id_ex_bubble(bub_a), .busy(busy_a), .err(err_a),
      .stall_cycles(cyc_a)
   );

   hazard_detect #(.REG_W(3), .CNT_W(2)) dut_b (
      .clk(clk), .rst(rst), .id_valid(id_valid),
      .id_rs(id_rs), .id_rs_vld(id_rs_vld), .id_rt(id_rt), .id_rt_vld(id_rt_vld),
      .ex_wr_en(ex_wr_en), .ex_wr_reg(ex_wr_reg),
      .mem_wr_en(mem_wr_en), .mem_wr_reg(mem_wr_reg), .flush(flush),
      .stall_count(sc_b), .id_ex_bubble(bub_b), .busy(busy_b), .err(err_b),
      .stall_cycles(cyc_b)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc_no, obs, exp);
      end
   endtask

   task automatic clr();
      rst = 1'b0; id_valid = 1'b0; id_rs = 3'd0; id_rs_vld = 1'b0;
      id_rt = 3'd0; id_rt_vld = 1'b0; ex_wr_en = 1'b0; ex_wr_reg = 3'd0;
      mem_wr_en = 1'b0; mem_wr_reg = 3'd0; flush = 1'b0;
   endtask

   // One clock of stimulus. Inputs are already applied. Outputs are compared
   // at the falling edge, then the model advances across the rising edge.
   task automatic cycle();
      int  m_sc;
      bit  m_bub, m_busy, m_err, exh, memh;
      @(negedge clk);
      exh  = ex_wr_en && ((id_rs_vld && id_rs == ex_wr_reg) || (id_rt_vld && id_rt == ex_wr_reg));
      memh = mem_wr_en && ((id_rs_vld && id_rs == mem_wr_reg) || (id_rt_vld && id_rt == mem_wr_reg));
      m_sc = 0; m_bub = 0; m_busy = 0; m_err = 0;
      if (!rst) begin
         if (pend > 0) begin
            m_busy = 1;
            m_bub  = !flush;
            m_err  = ex_wr_en || (!flush && exh);
         end else if (id_valid && !flush) begin
            if (exh) begin
               m_sc = 2; m_bub = 1;
            end else if (memh) begin
               m_sc = 1; m_bub = 1;
            end
         end
      end
      chk("a_stall_count", 32'(sc_a), 32'(m_sc));
      chk("a_bubble", 32'(bub_a), 32'(m_bub));
      chk("a_busy", 32'(busy_a), 32'(m_busy));
      chk("a_err", 32'(err_a), 32'(m_err));
      chk("a_stall_cycles", 32'(cyc_a), 32'(cnt_big));
      chk("b_stall_count", 32'(sc_b), 32'(m_sc));
      chk("b_bubble", 32'(bub_b), 32'(m_bub));
      chk("b_stall_cycles", 32'(cyc_b), 32'(cnt_small));
      if (rst) begin
         pend = 0; cnt_big = 0; cnt_small = 0;
      end else begin
         if (pend > 0) pend = pend - 1;
         else if (m_sc == 2) pend = 1;
         if (m_bub) begin
            if (cnt_big < 65535) cnt_big = cnt_big + 1;
            if (cnt_small < 3) cnt_small = cnt_small + 1;
         end
      end
      cyc_no++;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      clr(); rst = 1'b1; cycle(); rst = 1'b0;
   endtask

   task automatic ex_hazard(input logic [2:0] r);
      clr(); id_valid = 1; id_rs = r; id_rs_vld = 1; ex_wr_en = 1; ex_wr_reg = r;
   endtask

   initial begin
      clr();
      rst = 1'b1;
      @(posedge clk); #1;
      cycle();
      chk("reset_busy", 32'(busy_a), 32'd0);
      chk("reset_count", 32'(cyc_a), 32'd0);
      rst = 1'b0;

      // EX hazard followed by its HOLD cycle
      ex_hazard(3'd3); #1;
      chk("ex_code", 32'(sc_a), 32'd2);
      cycle();
      ex_wr_en = 0; mem_wr_en = 1; mem_wr_reg = 3'd3; #1;
      chk("hold_code", 32'(sc_a), 32'd0);
      chk("hold_busy", 32'(busy_a), 32'd1);
      chk("hold_bubble", 32'(bub_a), 32'd1);
      chk("hold_err", 32'(err_a), 32'd0);
      cycle();
      mem_wr_en = 0; #1;
      chk("after_hold_code", 32'(sc_a), 32'd0);
      chk("after_hold_count", 32'(cyc_a), 32'd2);
      cycle();

      // MEM-only hazard
      do_reset();
      clr(); id_valid = 1; id_rt = 3'd5; id_rt_vld = 1; mem_wr_en = 1; mem_wr_reg = 3'd5;
      ex_wr_en = 1; ex_wr_reg = 3'd2; #1;
      chk("mem_code", 32'(sc_a), 32'd1);
      chk("mem_busy", 32'(busy_a), 32'd0);
      cycle();
      clr(); #1;
      chk("mem_next_busy", 32'(busy_a), 32'd0);
      chk("mem_next_code", 32'(sc_a), 32'd0);
      chk("mem_count", 32'(cyc_a), 32'd1);
      cycle();

      // Priority and source qualifiers
      clr(); id_valid = 1; id_rs = 3'd1; id_rs_vld = 1; id_rt = 3'd4; id_rt_vld = 1;
      mem_wr_en = 1; mem_wr_reg = 3'd1; ex_wr_en = 1; ex_wr_reg = 3'd4; #1;
      chk("prio_ex", 32'(sc_a), 32'd2);
      cycle();
      clr(); cycle();
      id_valid = 1; id_rs = 3'd1; id_rs_vld = 1; id_rt = 3'd4; id_rt_vld = 0;
      mem_wr_en = 1; mem_wr_reg = 3'd1; ex_wr_en = 1; ex_wr_reg = 3'd4; #1;
      chk("prio_rt_off", 32'(sc_a), 32'd1);
      cycle();
      id_rt_vld = 1; ex_wr_en = 0; mem_wr_en = 0; #1;
      chk("prio_none", 32'(sc_a), 32'd0);
      cycle();

      // Flush in IDLE, then flush during HOLD
      ex_hazard(3'd6); flush = 1; #1;
      chk("flush_idle_code", 32'(sc_a), 32'd0);
      cycle();
      flush = 0; #1;
      chk("flush_stayed_idle", 32'(sc_a), 32'd2);
      cycle();
      clr(); flush = 1; #1;
      chk("flush_hold_bubble", 32'(bub_a), 32'd0);
      chk("flush_hold_busy", 32'(busy_a), 32'd1);
      cycle();
      clr(); #1;
      chk("flush_hold_exit", 32'(busy_a), 32'd0);
      cycle();

      // Error in HOLD, then reset abandoning HOLD
      ex_hazard(3'd2); cycle();
      ex_wr_en = 1; ex_wr_reg = 3'd2; #1;
      chk("err_hold", 32'(err_a), 32'd1);
      cycle();
      clr(); #1;
      chk("err_clears", 32'(err_a), 32'd0);
      cycle();
      ex_hazard(3'd7); cycle();
      clr(); rst = 1; #1;
      chk("rst_in_hold_busy", 32'(busy_a), 32'd0);
      cycle();
      rst = 0; #1;
      chk("after_rst_busy", 32'(busy_a), 32'd0);
      chk("after_rst_count", 32'(cyc_a), 32'd0);
      cycle();

      // Saturation with back-to-back EX hazards
      do_reset();
      for (int i = 0; i < 4; i++) begin
         ex_hazard(3'(i)); cycle();
         clr(); cycle();
      end
      #1;
      chk("sat_small", 32'(cyc_b), 32'd3);
      chk("sat_big", 32'(cyc_a), 32'd8);
      ex_hazard(3'd5); cycle(); clr(); cycle();
      chk("sat_small_hold", 32'(cyc_b), 32'd3);

      // Randomized traffic against the model
      for (int i = 0; i < 600; i++) begin
         rst        = ($urandom_range(0, 39) == 0);
         id_valid   = ($urandom_range(0, 3) != 0);
         id_rs      = 3'($urandom_range(0, 3));
         id_rs_vld  = 1'($urandom);
         id_rt      = 3'($urandom_range(0, 3));
         id_rt_vld  = 1'($urandom);
         ex_wr_en   = 1'($urandom);
         ex_wr_reg  = 3'($urandom_range(0, 3));
         mem_wr_en  = 1'($urandom);
         mem_wr_reg = 3'($urandom_range(0, 3));
         flush      = ($urandom_range(0, 7) == 0);
         cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
